// File: rtl/calc_accum_core_if.sv
// Instruction-fetch handshake: instruction memory is the master, calc_accum_core the slave.
interface calc_accum_core_if #(
  parameter int INSTR_W = 31
);
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/calc_accum_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MUL/HALT FSM, DEPTH-entry scratch file, shift-add MUL.
// Optional CALC_SATURATE_EN: clamp overflowing add/sub results instead of wrapping.
module calc_accum_core #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 14,
  parameter int DEPTH   = 8,
  parameter int FUNCT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  calc_accum_core_if.slave io_instr,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_acc_out,
  output logic             o_result_valid,
  output logic             o_overflow,
  output logic             o_halted
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [FUNCT_W-1:0] F_STORE = 3'b100;
  localparam logic [FUNCT_W-1:0] F_LOAD  = 3'b101;
  localparam logic [FUNCT_W-1:0] F_MUL   = 3'b110;
  localparam logic [FUNCT_W-1:0] F_HALT  = 3'b111;

  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm_a;
    logic [IMM_W-1:0]   imm_b;
  } instr_t;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MUL, S_HALT} state_t;

  state_t           r_state;
  instr_t           r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_acc;
  logic             r_result_valid;
  logic             r_overflow;
  logic             r_halted;
  logic [WIDTH-1:0] r_scr [DEPTH];
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [CNT_W-1:0] r_cnt;

  instr_t           w_instr;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_prod_nxt;
  logic             w_sub;
  logic             w_ovf;
  logic [IDX_W-1:0] w_idx;

  assign w_instr              = io_instr.instr;
  assign io_instr.instr_ready = (r_state == S_FETCH);

  // Add/sub datapath decodes the latched instruction: funct[1] picks acc over B, funct[0] subtracts.
  assign w_a   = WIDTH'($signed(r_instr.imm_a));
  assign w_b   = WIDTH'($signed(r_instr.imm_b));
  assign w_op2 = r_instr.funct[1] ? r_acc : w_b;
  assign w_sub = r_instr.funct[0];
  assign w_sum = w_sub ? (w_a - w_op2) : (w_a + w_op2);
  assign w_ovf = (w_sum[WIDTH-1] != w_a[WIDTH-1]) &&
                 (w_sub ? (w_a[WIDTH-1] != w_op2[WIDTH-1]) : (w_a[WIDTH-1] == w_op2[WIDTH-1]));
  assign w_idx = r_instr.imm_b[IDX_W-1:0];

`ifdef CALC_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = ~SMAX;
  // On overflow the true result lies on the side of operand A's sign.
  assign w_res = w_ovf ? (w_a[WIDTH-1] ? SMIN : SMAX) : w_sum;
`else
  assign w_res = w_sum;
`endif

  // Two's-complement product mod 2^WIDTH equals the unsigned one, so plain shift-add suffices.
  assign w_mul_a    = WIDTH'($signed(w_instr.imm_a));
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_FETCH;
      r_instr        <= '0;
      r_pc           <= '0;
      r_acc          <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_halted       <= 1'b0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_prod         <= '0;
      r_cnt          <= '0;
      for (int i = 0; i < DEPTH; i++) r_scr[i] <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (io_instr.instr_valid) begin
            r_instr <= w_instr;
            r_pc    <= r_pc + WIDTH'(4);
            case (w_instr.funct)
              F_MUL: begin
                r_state  <= S_MUL;
                r_mcand  <= r_acc;
                r_mplier <= w_mul_a;
                r_prod   <= '0;
                r_cnt    <= '0;
              end
              F_HALT: begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end
              default: r_state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          case (r_instr.funct)
            F_STORE: begin
              r_scr[w_idx] <= r_acc;
              r_overflow   <= 1'b0;
            end
            F_LOAD: begin
              r_acc      <= r_scr[w_idx];
              r_overflow <= 1'b0;
            end
            default: begin
              r_acc      <= w_res;
              r_overflow <= w_ovf;
            end
          endcase
          r_result_valid <= 1'b1;
          r_state        <= S_FETCH;
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_acc          <= w_prod_nxt;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= S_FETCH;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign o_pc           = r_pc;
  assign o_acc_out      = r_acc;
  assign o_result_valid = r_result_valid;
  assign o_overflow     = r_overflow;
  assign o_halted       = r_halted;
endmodule

// File: tb/tb_calc_accum_core.sv
// Directed bench for calc_accum_core at WIDTH=16, IMM_W=14, DEPTH=8.
module tb_calc_accum_core;
  localparam int W  = 16;
  localparam int IW = 14;
  localparam int N  = 3 + 2 * IW;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pc, acc;
  logic         rv, ovf, halted;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_pc  = '0;

  calc_accum_core_if #(.INSTR_W(N)) bus ();

  calc_accum_core #(.WIDTH(W), .IMM_W(IW), .DEPTH(8), .FUNCT_W(3)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .io_instr      (bus),
    .o_pc          (pc),
    .o_acc_out     (acc),
    .o_result_valid(rv),
    .o_overflow    (ovf),
    .o_halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mk(input logic [2:0] f, input int a, input int b);
    logic [IW-1:0] aa, bb;
    aa = a[IW-1:0];
    bb = b[IW-1:0];
    return {f, aa, bb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, return #1 after the accepting edge with valid dropped.
  task automatic send(input logic [N-1:0] ins);
    int n = 0;
    while (!bus.instr_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    tick();
    bus.instr_valid = 1'b0;
    exp_pc          = exp_pc + 16'd4;
  endtask

  // Single-cycle op: result lands one edge after accept.
  task automatic op(input logic [N-1:0] ins, input string tag,
                    input logic [W-1:0] e_acc, input logic e_ovf);
    send(ins);
    tick();
    chk({tag, "_rv"}, 32'(rv), 32'd1);
    chk({tag, "_acc"}, 32'(acc), 32'(e_acc));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
  endtask

  initial begin
    int bad;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    #12;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // ADDI 5,-3 with handshake timing
    send(mk(3'b000, 5, -3));
    chk("addi_ready_exec", 32'(bus.instr_ready), 32'd0);
    chk("addi_rv_early", 32'(rv), 32'd0);
    chk("addi_pc", 32'(pc), 32'd4);
    tick();
    chk("addi_rv", 32'(rv), 32'd1);
    chk("addi_acc", 32'(acc), 32'd2);
    chk("addi_ready_back", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("addi_rv_pulse", 32'(rv), 32'd0);

    // Scratch STORE/LOAD; immB=11 aliases to idx 3
    op(mk(3'b100, 0, 11), "store", 16'd2, 1'b0);
    op(mk(3'b000, 0, 0), "zero", 16'd0, 1'b0);
    op(mk(3'b101, 0, 3), "load", 16'd2, 1'b0);

    // Positive overflow chain
    op(mk(3'b000, 8191, 8191), "ov1", 16'h3FFE, 1'b0);
    op(mk(3'b010, 8191, 0), "ov2", 16'h5FFD, 1'b0);
    op(mk(3'b010, 8191, 0), "ov3", 16'h7FFC, 1'b0);
`ifdef CALC_SATURATE_EN
    op(mk(3'b010, 10, 0), "ov4", 16'h7FFF, 1'b1);
`else
    op(mk(3'b010, 10, 0), "ov4", 16'h8006, 1'b1);
`endif
    tick();
    chk("ovf_hold", 32'(ovf), 32'd1);
    op(mk(3'b001, 0, 1), "subi", 16'hFFFF, 1'b0);
    op(mk(3'b011, 5, 0), "accs", 16'h0006, 1'b0);

    // Negative side, then ACCS overflow 0 - (-32768)
    op(mk(3'b000, -8192, -8192), "neg1", 16'hC000, 1'b0);
    op(mk(3'b010, -8192, 0), "neg2", 16'hA000, 1'b0);
    op(mk(3'b010, -8192, 0), "neg3", 16'h8000, 1'b0);
`ifdef CALC_SATURATE_EN
    op(mk(3'b011, 0, 0), "accs_ov", 16'h7FFF, 1'b1);
`else
    op(mk(3'b011, 0, 0), "accs_ov", 16'h8000, 1'b1);
`endif

    // MUL -3*7 with instr_valid held high throughout
    op(mk(3'b000, -3, 0), "mul_pre", 16'hFFFD, 1'b0);
    bus.instr_valid = 1'b1;
    bus.instr       = mk(3'b110, 7, 0);
    tick();
    exp_pc    = exp_pc + 16'd4;
    bus.instr = mk(3'b000, 1, 1);
    bad       = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (bus.instr_ready !== 1'b0 || rv !== 1'b0) bad++;
    end
    chk("mul_busy", 32'(bad), 32'd0);
    tick();
    chk("mul_rv", 32'(rv), 32'd1);
    chk("mul_acc", 32'(acc), 32'h0000FFEB);
    chk("mul_pc", 32'(pc), 32'(exp_pc));
    bus.instr_valid = 1'b0;

    // MUL by negative operand: -21 * -2
    send(mk(3'b110, -2, 0));
    for (int k = 1; k <= 15; k++) tick();
    chk("mul2_rv_early", 32'(rv), 32'd0);
    tick();
    chk("mul2_acc", 32'(acc), 32'h002A);
    chk("mul2_ovf", 32'(ovf), 32'd0);

    // Asynchronous reset mid-MUL
    send(mk(3'b110, 3, 0));
    for (int k = 0; k < 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", 32'(acc), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_rv", 32'(rv), 32'd0);
    #3 rst_n = 1'b1;
    exp_pc = '0;
    tick();
    chk("arst_ready", 32'(bus.instr_ready), 32'd1);
    op(mk(3'b101, 0, 3), "arst_scr", 16'd0, 1'b0);

    // HALT is terminal
    op(mk(3'b000, 1, 2), "pre_halt", 16'd3, 1'b0);
    send(mk(3'b111, 0, 0));
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_ready", 32'(bus.instr_ready), 32'd0);
    bus.instr_valid = 1'b1;
    bus.instr       = mk(3'b000, 4, 4);
    bad             = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rv !== 1'b0 || bus.instr_ready !== 1'b0) bad++;
    end
    bus.instr_valid = 1'b0;
    chk("halt_quiet", 32'(bad), 32'd0);
    chk("halt_pc", 32'(pc), 32'(exp_pc));
    chk("halt_acc", 32'(acc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
